// File: rtl/cdc_handshake_tx_pkg.sv
// Shared constants for the source half of the two-phase CDC handshake.
// Holds the FSM state encoding and the shortest ack synchronizer chain that is allowed.
package cdc_handshake_tx_pkg;

  typedef logic [0:0] state_t;

  localparam state_t ST_IDLE     = 1'b0;
  localparam state_t ST_WAIT_ACK = 1'b1;

  localparam int unsigned MIN_SYNC_STAGES = 32'd2;

endpackage

// File: rtl/cdc_handshake_tx_pipeline.sv
// Reset-to-zero flop chain, used as the multi-flop synchronizer for asynchronous inputs.
// The output q is taken from the last stage only.
module pipeline
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32'd1,
  parameter int unsigned SYNC_STAGES = MIN_SYNC_STAGES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] d,
  output logic [DATA_WIDTH-1:0] q
);

  logic [DATA_WIDTH-1:0] stage_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] stage_d [SYNC_STAGES];

  // shift the chain by one stage per clock
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < int'(SYNC_STAGES); i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // chain registers, cleared on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain side of a two-phase toggle CDC handshake: accepts a word, holds it on
// xfer_data, toggles xfer_req and waits for the synchronized ack toggle to match.
module cdc_handshake_tx
  import cdc_handshake_tx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32'd8,
  parameter int unsigned SYNC_STAGES = 32'd2,
  parameter int unsigned ACK_TIMEOUT = 32'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  xfer_req,
  output logic [DATA_WIDTH-1:0] xfer_data,
  input  logic                  xfer_ack_async,
  output logic                  done,
  output logic                  busy,
  output logic                  timeout
);

  localparam int unsigned STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int unsigned CNT_W  = (ACK_TIMEOUT > 32'd1) ? $clog2(ACK_TIMEOUT + 32'd1) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TO_LAST = (ACK_TIMEOUT > 32'd0) ? CNT_W'(ACK_TIMEOUT - 32'd1) : '0;

  state_t                state_q, state_d;
  logic                  xfer_req_q, xfer_req_d;
  logic [DATA_WIDTH-1:0] xfer_data_q, xfer_data_d;
  logic                  done_q, done_d;
  logic                  timeout_q, timeout_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ack_sync;
  logic                  accept_s;
  logic                  ack_seen_s;

  pipeline #(
    .DATA_WIDTH  (1),
    .SYNC_STAGES (STAGES)
  ) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d   (xfer_ack_async),
    .q   (ack_sync)
  );

  assign accept_s   = (state_q == ST_IDLE) && in_valid;
  assign ack_seen_s = (state_q == ST_WAIT_ACK) && (ack_sync == xfer_req_q);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) state_d = ST_WAIT_ACK;
        else          state_d = ST_IDLE;
      end
      ST_WAIT_ACK: begin
        if (ack_sync == xfer_req_q) state_d = ST_IDLE;
        else                        state_d = ST_WAIT_ACK;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state-decoded handshake outputs
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      ST_WAIT_ACK: begin
        in_ready = 1'b0;
        busy     = 1'b1;
      end
      default: begin
        in_ready = 1'b0;
        busy     = 1'b0;
      end
    endcase
  end

  // request/data capture, completion pulse and saturating wait counter
  always_comb begin
    xfer_req_d  = xfer_req_q;
    xfer_data_d = xfer_data_q;
    cnt_d       = cnt_q;
    timeout_d   = timeout_q;
    done_d      = ack_seen_s;
    if (accept_s) begin
      xfer_req_d  = ~xfer_req_q;
      xfer_data_d = in_data;
      cnt_d       = '0;
    end else if ((state_q == ST_WAIT_ACK) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1'b1);
    end else begin
      cnt_d = cnt_q;
    end
    // the flag is sticky: only reset clears it, the wait itself carries on
    if ((ACK_TIMEOUT != 32'd0) && (state_q == ST_WAIT_ACK) && (cnt_q == TO_LAST)) begin
      timeout_d = 1'b1;
    end else begin
      timeout_d = timeout_q;
    end
  end

  // datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      xfer_req_q  <= xfer_req_d;
      xfer_data_q <= xfer_data_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
      cnt_q       <= cnt_d;
    end
  end

  assign xfer_req  = xfer_req_q;
  assign xfer_data = xfer_data_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed self-checking bench for cdc_handshake_tx (SYNC_STAGES=2, ACK_TIMEOUT=8).
module tb_cdc_handshake_tx;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       xfer_req;
  logic [7:0] xfer_data;
  logic       xfer_ack_async;
  logic       done;
  logic       busy;
  logic       timeout;

  int n_checks;
  int n_errors;
  int done_cnt;

  cdc_handshake_tx #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2),
    .ACK_TIMEOUT (8)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .xfer_req       (xfer_req),
    .xfer_data      (xfer_data),
    .xfer_ack_async (xfer_ack_async),
    .done           (done),
    .busy           (busy),
    .timeout        (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    done_cnt       = 0;
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_data        = 8'h00;
    xfer_ack_async = 1'b0;

    // reset state
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_xfer_req", xfer_req, 0);
    check_eq("rst_xfer_data", xfer_data, 8'h00);
    check_eq("rst_done", done, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_timeout", timeout, 0);

    // single transfer of 0xA5, then hold stability with a competing offer of 0x3C
    in_valid = 1'b1;
    in_data  = 8'hA5;
    tick();
    check_eq("acc_xfer_data", xfer_data, 8'hA5);
    check_eq("acc_xfer_req", xfer_req, 1);
    check_eq("acc_busy", busy, 1);
    check_eq("acc_in_ready", in_ready, 0);
    in_data        = 8'h3C;
    xfer_ack_async = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i < 3) begin
        check_eq("hold_done", done, 0);
        check_eq("hold_data", xfer_data, 8'hA5);
        check_eq("hold_req", xfer_req, 1);
        check_eq("hold_busy", busy, 1);
      end else begin
        check_eq("single_done", done, 1);
        check_eq("single_in_ready", in_ready, 1);
        check_eq("single_busy", busy, 0);
      end
    end
    in_valid = 1'b0;
    tick();
    check_eq("single_done_pulse", done, 0);
    check_eq("single_idle_data", xfer_data, 8'hA5);
    check_eq("single_idle_busy", busy, 0);
    check_eq("single_timeout", timeout, 0);

    // back-to-back 0x11 then 0x22, responder toggles ack 4 cycles after each request
    in_valid = 1'b1;
    in_data  = 8'h11;
    for (int t = 0; t < 16; t++) begin
      tick();
      if (t == 0) in_data = 8'h22;
      if (done) done_cnt++;
      check_eq("b2b_done", done, ((t == 7) || (t == 15)) ? 1 : 0);
      check_eq("b2b_req", xfer_req, (t >= 8) ? 1 : 0);
      check_eq("b2b_data", xfer_data, (t >= 8) ? 8'h22 : 8'h11);
      check_eq("b2b_busy", busy, ((t == 7) || (t == 15)) ? 0 : 1);
      if (t == 4)  xfer_ack_async = 1'b0;
      if (t == 8)  in_valid = 1'b0;
      if (t == 12) xfer_ack_async = 1'b1;
    end
    check_eq("b2b_done_count", done_cnt, 2);
    check_eq("b2b_timeout", timeout, 0);

    // timeout: accept 0x5A and leave the ack alone
    rst            = 1'b1;
    xfer_ack_async = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("to_rst_timeout", timeout, 0);
    in_valid = 1'b1;
    in_data  = 8'h5A;
    tick();
    in_valid = 1'b0;
    check_eq("to_acc_req", xfer_req, 1);
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_eq("to_flag", timeout, (k >= 8) ? 1 : 0);
      check_eq("to_busy", busy, 1);
      check_eq("to_data", xfer_data, 8'h5A);
    end
    xfer_ack_async = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_eq("to_late_done", done, (k == 3) ? 1 : 0);
      check_eq("to_sticky", timeout, 1);
    end

    // reset in the middle of a transfer of 0x77
    in_valid = 1'b1;
    in_data  = 8'h77;
    tick();
    in_valid = 1'b0;
    check_eq("mid_acc_req", xfer_req, 0);
    check_eq("mid_acc_busy", busy, 1);
    tick();
    check_eq("mid_busy2", busy, 1);
    rst            = 1'b1;
    xfer_ack_async = 1'b0;
    tick();
    rst = 1'b0;
    check_eq("mid_rst_in_ready", in_ready, 1);
    check_eq("mid_rst_req", xfer_req, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_data", xfer_data, 8'h00);
    check_eq("mid_rst_timeout", timeout, 0);
    for (int k = 0; k < 4; k++) begin
      check_eq("mid_rst_no_done", done, 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
